// File: rtl/sv_mexp.sv
// sv_mexp: constant-time left-to-right square-and-multiply modular exponentiation.
// Computes p = b^e mod q by driving an external modular multiplier over start/ready.
module sv_mexp #(
    parameter int DATA_WIDTH = 512,
    parameter int EXP_WIDTH  = 512
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic                           v_i,
    input  logic [DATA_WIDTH/8-1:0][7:0]   b_i,
    input  logic [EXP_WIDTH-1:0]           e_i,
    input  logic [DATA_WIDTH/8-1:0][7:0]   q_i,
    output logic [DATA_WIDTH/8-1:0][7:0]   p_o,
    output logic                           v_o,
    output logic                           ready,
    output logic                           mul_v_o,
    output logic [DATA_WIDTH/8-1:0][7:0]   mul_x_o,
    output logic [DATA_WIDTH/8-1:0][7:0]   mul_y_o,
    output logic [DATA_WIDTH/8-1:0][7:0]   mul_q_o,
    input  logic [DATA_WIDTH/8-1:0][7:0]   mul_p_i,
    input  logic                           mul_ready_i
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SQR_ISSUE = 3'd1;
    localparam logic [2:0] S_SQR_WAIT  = 3'd2;
    localparam logic [2:0] S_MUL_ISSUE = 3'd3;
    localparam logic [2:0] S_MUL_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]           r_state;
    logic [NB-1:0][7:0]   r_r;
    logic [NB-1:0][7:0]   r_b;
    logic [NB-1:0][7:0]   r_q;
    logic [NB-1:0][7:0]   r_p;
    logic [EXP_WIDTH-1:0] r_e;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_wait_first;

    logic                 w_issue;
    logic                 w_mul_done;
    logic [NB-1:0][7:0]   w_mul_r;

    assign w_issue    = ((r_state == S_SQR_ISSUE) || (r_state == S_MUL_ISSUE)) && mul_ready_i;
    assign w_mul_done = !r_wait_first && mul_ready_i;
    // The multiply product is always consumed on the bus but only kept for a 1 bit.
    assign w_mul_r    = r_e[r_idx] ? mul_p_i : r_r;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_r          <= '0;
            r_b          <= '0;
            r_q          <= '0;
            r_p          <= '0;
            r_e          <= '0;
            r_idx        <= '0;
            r_wait_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (v_i) begin
                        r_b     <= b_i;
                        r_e     <= e_i;
                        r_q     <= q_i;
                        r_r     <= DATA_WIDTH'(1);
                        r_idx   <= IDX_W'(EXP_WIDTH - 1);
                        r_state <= S_SQR_ISSUE;
                    end
                end
                S_SQR_ISSUE: begin
                    if (mul_ready_i) begin
                        r_wait_first <= 1'b1;
                        r_state      <= S_SQR_WAIT;
                    end
                end
                S_SQR_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_mul_done) begin
                        r_r     <= mul_p_i;
                        r_state <= S_MUL_ISSUE;
                    end
                end
                S_MUL_ISSUE: begin
                    if (mul_ready_i) begin
                        r_wait_first <= 1'b1;
                        r_state      <= S_MUL_WAIT;
                    end
                end
                S_MUL_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_mul_done) begin
                        r_r <= w_mul_r;
                        if (r_idx == '0) begin
                            // Load the result on entry to DONE so p_o is valid alongside v_o.
                            r_p     <= w_mul_r;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx - IDX_W'(1);
                            r_state <= S_SQR_ISSUE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        mul_x_o = '0;
        mul_y_o = '0;
        case (r_state)
            S_SQR_ISSUE, S_SQR_WAIT: begin
                mul_x_o = r_r;
                mul_y_o = r_r;
            end
            S_MUL_ISSUE, S_MUL_WAIT: begin
                mul_x_o = r_r;
                mul_y_o = r_b;
            end
            default: ;
        endcase
    end

    assign mul_v_o = w_issue;
    assign mul_q_o = r_q;
    assign ready   = (r_state == S_IDLE);
    assign v_o     = (r_state == S_DONE);
    assign p_o     = r_p;

endmodule

// File: tb/tb_sv_mexp.sv
// Bench for sv_mexp: table-driven and random jobs against a repeated-multiplication
// reference, with a behavioural modular multiplier whose ready drops for L cycles per job.
module tb_sv_mexp;

    localparam int DW    = 16;
    localparam int EW    = 8;
    localparam int NB    = DW / 8;
    localparam int L     = 5;
    localparam int LIMIT = 2000;

    logic                 clk = 1'b0;
    logic                 areset;
    logic                 v_i;
    logic [NB-1:0][7:0]   b_i;
    logic [EW-1:0]        e_i;
    logic [NB-1:0][7:0]   q_i;
    logic [NB-1:0][7:0]   p_o;
    logic                 v_o;
    logic                 ready;
    logic                 mul_v_o;
    logic [NB-1:0][7:0]   mul_x_o;
    logic [NB-1:0][7:0]   mul_y_o;
    logic [NB-1:0][7:0]   mul_q_o;
    logic [NB-1:0][7:0]   mul_p_i = '0;
    logic                 mul_ready_i;

    int   busy      = 0;
    logic hold      = 1'b0;
    int   pulse_cnt = 0;
    int   proto_err = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    sv_mexp #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
        .clk(clk), .areset(areset), .v_i(v_i), .b_i(b_i), .e_i(e_i), .q_i(q_i),
        .p_o(p_o), .v_o(v_o), .ready(ready), .mul_v_o(mul_v_o),
        .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_q_o(mul_q_o),
        .mul_p_i(mul_p_i), .mul_ready_i(mul_ready_i)
    );

    function automatic logic [15:0] mulmod(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] q);
        longint unsigned t;
        if (q == 16'd0) return 16'd0;
        t = (longint'(x) * longint'(y)) % longint'(q);
        return 16'(t);
    endfunction

    // Reference: b multiplied into an accumulator e times, reduced mod q each step.
    function automatic logic [15:0] pow_ref(input logic [15:0] b, input logic [7:0] e,
                                            input logic [15:0] q);
        longint unsigned r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * longint'(b)) % longint'(q);
        return 16'(r);
    endfunction

    // Multiplier model: accepts a job when idle, then holds ready low for L cycles.
    assign mul_ready_i = (busy == 0) && !hold;

    always @(posedge clk) begin
        if (mul_v_o && !mul_ready_i) proto_err <= proto_err + 1;
        if (mul_v_o && mul_ready_i) begin
            busy      <= L;
            mul_p_i   <= mulmod(mul_x_o, mul_y_o, mul_q_o);
            pulse_cnt <= pulse_cnt + 1;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present operands with v_i high and return right after the accepting edge.
    task automatic start_job(input logic [15:0] b, input logic [7:0] e, input logic [15:0] q,
                             output int waits, output int pc0);
        b_i   = b;
        e_i   = e;
        q_i   = q;
        v_i   = 1'b1;
        waits = 0;
        while (!ready && waits < LIMIT) begin
            @(posedge clk);
            @(negedge clk);
            waits++;
        end
        check("accept_ready", ready, 1);
        pc0 = pulse_cnt;
        @(posedge clk);
    endtask

    // Run until v_o; k is the cycle index counted from the accept cycle (cycle 0).
    task automatic finish_job(input bit do_hold, input bit poke, input int pc0,
                              output logic [15:0] p, output int lat, output int pulses,
                              output int first);
        int k;
        bit got;
        k     = 1;
        got   = 1'b0;
        first = -1;
        for (int n = 0; n < LIMIT && !got; n++) begin
            @(negedge clk);
            if (k == 1) v_i = 1'b0;
            if (do_hold && k == 4) hold = 1'b0;
            if (poke && k == 20) begin
                v_i = 1'b1;
                b_i = 16'h0005;
                e_i = 8'h03;
                q_i = 16'h000b;
            end
            if (poke && k == 21) v_i = 1'b0;
            #1;
            if (mul_v_o && first < 0) first = k;
            if (v_o) got = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        check("v_o_seen", got, 1);
        p      = p_o;
        lat    = got ? k : -1;
        pulses = pulse_cnt - pc0;
    endtask

    typedef struct {
        logic [15:0] b;
        logic [7:0]  e;
        logic [15:0] q;
        logic [15:0] p;
        bit          hold;
        bit          poke;
        int          lat;
        int          first;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] p, rb, rq;
        logic [7:0]  re;
        int          lat, pulses, first, waits, pc0, k;

        vecs[0] = '{16'd3,      8'd5,    16'd7,      16'd5,  1'b0, 1'b0, 113, 1};
        vecs[1] = '{16'd2,      8'd10,   16'd1000,   16'd24, 1'b0, 1'b1, 113, 1};
        vecs[2] = '{16'h0123,   8'hFF,   16'hFFF1,   16'd0,  1'b0, 1'b0, 113, 1};
        vecs[2].p = pow_ref(16'h0123, 8'hFF, 16'hFFF1);
        vecs[3] = '{16'd9,      8'd0,    16'd11,     16'd1,  1'b0, 1'b0, 113, 1};
        vecs[4] = '{16'd0,      8'd7,    16'd13,     16'd0,  1'b0, 1'b0, 113, 1};
        vecs[5] = '{16'd3,      8'd5,    16'd7,      16'd5,  1'b1, 1'b0, 116, 4};

        areset = 1'b1;
        v_i    = 1'b0;
        b_i    = '0;
        e_i    = '0;
        q_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   ready,   1);
        check("rst_v_o",     v_o,     0);
        check("rst_mul_v_o", mul_v_o, 0);
        check("rst_p_o",     p_o,     0);
        check("rst_mul_x",   mul_x_o, 0);
        check("rst_mul_y",   mul_y_o, 0);
        check("rst_mul_q",   mul_q_o, 0);
        areset = 1'b0;

        // Jobs run back to back: each next v_i is raised in the DONE cycle of the previous one.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].hold) hold = 1'b1;
            start_job(vecs[i].b, vecs[i].e, vecs[i].q, waits, pc0);
            finish_job(vecs[i].hold, vecs[i].poke, pc0, p, lat, pulses, first);
            check($sformatf("vec%0d_p", i),      p,      vecs[i].p);
            check($sformatf("vec%0d_lat", i),    lat,    vecs[i].lat);
            check($sformatf("vec%0d_pulses", i), pulses, 16);
            check($sformatf("vec%0d_first", i),  first,  vecs[i].first);
            check($sformatf("vec%0d_ready_done", i), ready, 0);
            if (i > 0) check($sformatf("vec%0d_b2b_wait", i), waits, 1);
        end

        for (int i = 0; i < 20; i++) begin
            rq = 16'($urandom_range(65535, 2));
            rb = 16'($urandom_range(int'(rq) - 1, 0));
            re = 8'($urandom_range(255, 0));
            start_job(rb, re, rq, waits, pc0);
            finish_job(1'b0, 1'b0, pc0, p, lat, pulses, first);
            check($sformatf("rnd%0d_p b=%0d e=%0d q=%0d", i, rb, re, rq), p, pow_ref(rb, re, rq));
            check($sformatf("rnd%0d_lat", i), lat, 113);
        end

        // Abort a job at cycle 40 with a multiplier job in flight, then restart.
        start_job(16'd3, 8'd5, 16'd7, waits, pc0);
        k = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (k == 1) v_i = 1'b0;
            if (k == 40) break;
            @(posedge clk);
            k++;
        end
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_ready",   ready,   1);
        check("abort_mul_v_o", mul_v_o, 0);
        check("abort_v_o",     v_o,     0);
        check("abort_p_o",     p_o,     0);
        check("abort_mul_q",   mul_q_o, 0);
        areset = 1'b0;
        repeat (9) @(negedge clk);
        start_job(16'd2, 8'd10, 16'd1000, waits, pc0);
        finish_job(1'b0, 1'b0, pc0, p, lat, pulses, first);
        check("restart_p",      p,      24);
        check("restart_lat",    lat,    113);
        check("restart_pulses", pulses, 16);

        check("mul_v_o_while_busy", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sv_mexp.md
Name: sv_mexp

Overview:
- Modular exponentiation controller: computes p = b^e mod q by issuing square and multiply jobs to an external modular multiplier (sv_mc-compatible) over its start/ready interface.
- Acts as the initiator of that interface and is the consumer of the multiplier's product.
- Sits between signature-level control logic and the modular multiplier.
- Fixed constant-time operation sequence, independent of the exponent value.

Parameters:
- DATA_WIDTH, 512, operand/modulus width in bits; must be a multiple of 8.
- EXP_WIDTH, 512, exponent width in bits; number of exponent bits processed per job.

Ports:
- clk  input  1  clock; all logic on rising edge.
- areset  input  1  reset, synchronous, active-high.
- v_i  input  1  start request; accepted when v_i & ready.
- b_i  input  [7:0] x DATA_WIDTH/8  base, byte 0 least significant.
- e_i  input  EXP_WIDTH  exponent.
- q_i  input  [7:0] x DATA_WIDTH/8  modulus, byte 0 least significant.
- p_o  output  [7:0] x DATA_WIDTH/8  result; holds its value until the next v_o.
- v_o  output  1  one-cycle pulse; p_o is valid in the same cycle.
- ready  output  1  high in IDLE only.
- mul_v_o  output  1  multiplier start pulse.
- mul_x_o  output  [7:0] x DATA_WIDTH/8  multiplier operand x.
- mul_y_o  output  [7:0] x DATA_WIDTH/8  multiplier operand y.
- mul_q_o  output  [7:0] x DATA_WIDTH/8  modulus to the multiplier; equals latched q.
- mul_p_i  input  [7:0] x DATA_WIDTH/8  multiplier product.
- mul_ready_i  input  1  multiplier idle; product valid while high after a job.

Behaviour:
- Reset values: state IDLE; ready=1; v_o=0; mul_v_o=0; p_o=0; mul_x_o, mul_y_o, mul_q_o=0; internal registers (r, b, e, q, bit index) cleared.
- Reset taken mid-operation: abort immediately and enter IDLE. The in-flight multiplier job is abandoned; its later completion is ignored.
- Accept (IDLE, v_i=1, cycle 0):
  - Latch b_i, e_i, q_i.
  - Set r=1, idx=EXP_WIDTH-1.
  - Go to SQR_ISSUE.
  - v_i is ignored when ready=0.
- States: IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- SQR_ISSUE:
  - Drive mul_x_o=r, mul_y_o=r.
  - If mul_ready_i=1: pulse mul_v_o for one cycle and go to SQR_WAIT.
  - Otherwise hold, with mul_v_o=0.
- SQR_WAIT:
  - Ignore mul_ready_i in the first cycle of this state (the cycle right after the pulse).
  - From then on, when mul_ready_i=1: r<=mul_p_i and go to MUL_ISSUE.
- MUL_ISSUE: same as SQR_ISSUE with mul_x_o=r, mul_y_o=b.
- MUL_WAIT:
  - Same first-cycle rule as SQR_WAIT.
  - On mul_ready_i=1: if e[idx]=1 then r<=mul_p_i, else discard the product (r unchanged).
  - Then if idx==0 go to DONE; otherwise idx<=idx-1 and go to SQR_ISSUE.
- Constant time: the multiply is always issued, whatever the bit value. Every job runs exactly 2*EXP_WIDTH multiplier operations.
- DONE: one cycle; p_o<=r, v_o=1, then IDLE. ready=1 from the cycle after DONE.
- mul_x_o/mul_y_o stay stable from the ISSUE state through the end of the matching WAIT state.
- mul_v_o is never asserted while mul_ready_i=0 or outside the ISSUE states.
- Latency: with a multiplier whose ready is low for L cycles after each pulse, v_o rises exactly 2*EXP_WIDTH*(L+2)+1 cycles after accept.
- Boundaries:
  - e=0 gives p=1 (full sequence still runs).
  - b=0 with e>0 gives 0.
  - Preconditions: q>1 and b<q. Results outside these are unspecified but the block must not hang.
- A v_i held high during DONE is not accepted until IDLE.

Test Plan:
- Bench setup: DATA_WIDTH=16, EXP_WIDTH=8, behavioural multiplier model with L=5.
- b=3, e=5, q=7 -> p_o=5; v_o exactly 113 cycles after accept; 16 mul_v_o pulses seen.
- b=2, e=10, q=1000 -> p_o=24. Back-to-back job b=0x0123, e=0xFF, q=0xFFF1 -> p_o matches the reference model; second job starts the cycle after ready rises.
- e=0, b=9, q=11 -> p_o=1 after 113 cycles. b=0, e=7, q=13 -> p_o=0.
- Multiplier model holds mul_ready_i low 3 extra cycles before the first issue -> mul_v_o delayed accordingly; result unchanged; latency +3.
- Assert areset at cycle 40 of a job -> next cycle: ready=1, mul_v_o=0, v_o=0, p_o=0. A new job accepted 10 cycles later yields the correct result despite the late product from the abandoned job.
- v_i pulsed mid-job with different operands -> ignored; original result delivered.
